// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
// Optional macro BTB_2BIT_EN adds a 2-bit saturating counter to each BTB entry.
package fetch_pkg;

    localparam int unsigned FETCH_AW        = 5;
    localparam int unsigned FETCH_BTB_IDX_W = 4;
    localparam int unsigned FETCH_BTB_TAG_W = FETCH_AW - FETCH_BTB_IDX_W;

    localparam logic [31:0] BUBBLE    = 32'hF800_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic                       valid;
        logic [FETCH_BTB_TAG_W-1:0] tag;
        logic [FETCH_AW-1:0]        target;
`ifdef BTB_2BIT_EN
        logic [1:0]                 ctr;
`endif
    } btb_entry_t;

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup, registered update.
// BTB_2BIT_EN selects counter-based prediction instead of valid-bit only.
module fetch_btb
    import fetch_pkg::*;
#(
    parameter int unsigned AW        = FETCH_AW,
    parameter int unsigned BTB_IDX_W = FETCH_BTB_IDX_W
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_lookup_pc,
    output logic          o_hit_c,
    output logic [AW-1:0] o_target_c,
    input  logic          i_upd_valid,
    input  logic [AW-1:0] i_upd_pc,
    input  logic [AW-1:0] i_upd_target,
    input  logic          i_upd_taken,
    input  logic          i_upd_uncond
);

    localparam int unsigned DEPTH = 2 ** BTB_IDX_W;
    localparam int unsigned TAG_W = AW - BTB_IDX_W;

    btb_entry_t r_mem [DEPTH];

    logic [BTB_IDX_W-1:0] w_lk_idx;
    logic [BTB_IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0]     w_lk_tag;
    logic [TAG_W-1:0]     w_up_tag;
    btb_entry_t           w_lk_ent;
    btb_entry_t           w_up_ent;
    btb_entry_t           w_up_next;
    logic                 w_lk_match;
    logic                 w_up_match;
    logic                 w_up_we;

    assign w_lk_idx   = i_lookup_pc[BTB_IDX_W-1:0];
    assign w_lk_tag   = i_lookup_pc[AW-1:BTB_IDX_W];
    assign w_up_idx   = i_upd_pc[BTB_IDX_W-1:0];
    assign w_up_tag   = i_upd_pc[AW-1:BTB_IDX_W];
    assign w_lk_ent   = r_mem[w_lk_idx];
    assign w_up_ent   = r_mem[w_up_idx];
    assign w_lk_match = w_lk_ent.valid && (w_lk_ent.tag == w_lk_tag);
    assign w_up_match = w_up_ent.valid && (w_up_ent.tag == w_up_tag);

`ifdef BTB_2BIT_EN
    assign o_hit_c    = w_lk_match && w_lk_ent.ctr[1];
`else
    assign o_hit_c    = w_lk_match;
`endif
    assign o_target_c = w_lk_ent.target;

    // Next contents of the entry addressed by the resolving branch
    always_comb begin
        w_up_next = w_up_ent;
        w_up_we   = 1'b0;
`ifdef BTB_2BIT_EN
        if (i_upd_valid) begin
            if (w_up_match) begin
                w_up_we = 1'b1;
                if (i_upd_taken) begin
                    w_up_next.target = i_upd_target;
                    if (w_up_ent.ctr != 2'd3) begin
                        w_up_next.ctr = w_up_ent.ctr + 2'd1;
                    end
                end else if (w_up_ent.ctr != 2'd0) begin
                    w_up_next.ctr = w_up_ent.ctr - 2'd1;
                end
            end else if (i_upd_taken) begin
                w_up_we          = 1'b1;
                w_up_next.valid  = 1'b1;
                w_up_next.tag    = w_up_tag;
                w_up_next.target = i_upd_target;
                w_up_next.ctr    = 2'd2;
            end
        end
`else
        if (i_upd_valid && i_upd_taken && i_upd_uncond) begin
            w_up_we          = 1'b1;
            w_up_next.valid  = 1'b1;
            w_up_next.tag    = w_up_tag;
            w_up_next.target = i_upd_target;
        end else if (i_upd_valid && !i_upd_taken && w_up_match) begin
            w_up_we          = 1'b1;
            w_up_next.valid  = 1'b0;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_up_we) begin
            r_mem[w_up_idx] <= w_up_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PCF, BTB-driven next-PC selection, F->D latch and halt FSM.
// Build with BTB_2BIT_EN for counter-based branch prediction.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned AW        = FETCH_AW,
    parameter int unsigned BTB_IDX_W = FETCH_BTB_IDX_W
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          stall_f,
    input  logic          stall_d,
    input  logic          flush_d,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    input  logic          btb_upd_valid,
    input  logic [AW-1:0] btb_upd_pc,
    input  logic [AW-1:0] btb_upd_target,
    input  logic          btb_upd_taken,
    input  logic          btb_upd_uncond,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    output logic [31:0]   instr_d,
    output logic [AW-1:0] pc_d,
    output logic          pred_taken_d,
    output logic          halted
);

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    logic [AW-1:0] r_pcf;
    logic [AW-1:0] w_pcf_nxt;
    logic          r_pcf_pred;
    logic          w_pcf_pred_nxt;
    logic [31:0]   r_instr_d;
    logic [31:0]   w_instr_nxt;
    logic [AW-1:0] r_pc_d;
    logic [AW-1:0] w_pc_nxt;
    logic          r_pred_d;
    logic          w_pred_nxt;
    logic          w_btb_hit;
    logic [AW-1:0] w_btb_target;

    fetch_btb #(
        .AW        (AW),
        .BTB_IDX_W (BTB_IDX_W)
    ) u_btb (
        .i_clk        (CLOCK_50),
        .i_reset      (reset),
        .i_lookup_pc  (r_pcf),
        .o_hit_c      (w_btb_hit),
        .o_target_c   (w_btb_target),
        .i_upd_valid  (btb_upd_valid),
        .i_upd_pc     (btb_upd_pc),
        .i_upd_target (btb_upd_target),
        .i_upd_taken  (btb_upd_taken),
        .i_upd_uncond (btb_upd_uncond)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_pcf_pred marks that PCF was reached through a predicted-taken target
    always_comb begin
        w_state_nxt    = r_state;
        w_pcf_nxt      = r_pcf;
        w_pcf_pred_nxt = r_pcf_pred;
        w_instr_nxt    = r_instr_d;
        w_pc_nxt       = r_pc_d;
        w_pred_nxt     = r_pred_d;

        case (r_state)
            RUN:     if ((r_instr_d == HALT_WORD) && !redirect_valid) w_state_nxt = HALT;
            HALT:    if (redirect_valid) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase

        if (redirect_valid) begin
            w_pcf_nxt      = redirect_pc;
            w_pcf_pred_nxt = 1'b0;
        end else if ((r_state == HALT) || stall_f) begin
            w_pcf_nxt      = r_pcf;
        end else if (w_btb_hit) begin
            w_pcf_nxt      = w_btb_target;
            w_pcf_pred_nxt = 1'b1;
        end else begin
            w_pcf_nxt      = r_pcf + AW'(1);
            w_pcf_pred_nxt = 1'b0;
        end

        if (redirect_valid || flush_d || (r_state == HALT)) begin
            w_instr_nxt = BUBBLE;
            w_pred_nxt  = 1'b0;
        end else if (!stall_d) begin
            w_instr_nxt = imem_rdata;
            w_pc_nxt    = r_pcf;
            w_pred_nxt  = r_pcf_pred;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_pcf      <= '0;
            r_pcf_pred <= 1'b0;
            r_instr_d  <= BUBBLE;
            r_pc_d     <= '0;
            r_pred_d   <= 1'b0;
        end else begin
            r_pcf      <= w_pcf_nxt;
            r_pcf_pred <= w_pcf_pred_nxt;
            r_instr_d  <= w_instr_nxt;
            r_pc_d     <= w_pc_nxt;
            r_pred_d   <= w_pred_nxt;
        end
    end

    assign imem_addr    = r_pcf;
    assign instr_d      = r_instr_d;
    assign pc_d         = r_pc_d;
    assign pred_taken_d = r_pred_d;
    assign halted       = (r_state == HALT);

endmodule
